// File: rtl/knn_topk_vote.sv
// KNN back end: keeps the K nearest (distance, label) samples of one query in a
// sorted list, then tallies votes per class and resolves the winning class.
`timescale 1ns/1ps

module knn_topk_vote #(
    parameter int DIST_W    = 14,
    parameter int LABEL_W   = 4,
    parameter int K         = 5,
    parameter int NUM_CLASS = 5,
    parameter int TIE_MODE  = 0,
    parameter int VOTE_W    = $clog2(K + 1)
) (
    input  logic               clk_en,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               busy,
    output logic               label_err,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [LABEL_W-1:0] result_label,
    output logic [VOTE_W-1:0]  result_votes,
    output logic [DIST_W-1:0]  result_min_dist,
    output logic               result_empty,
    output logic [2:0]         state_dbg
);

    // Handshakes: a sample transfers on a rising edge with in_valid && in_ready;
    // a result transfers with result_valid && result_ready. A producer holds its
    // data stable while its valid is high and the transfer has not happened.

    localparam int IDX_W = $clog2(K + 1);
    localparam int NLAB  = 2 ** LABEL_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VOTE    = 3'd2,
        S_RESOLVE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [K-1:0]       slot_valid;
    logic [DIST_W-1:0]  slot_dist  [K];
    logic [LABEL_W-1:0] slot_label [K];

    logic [VOTE_W-1:0]  cnt  [NLAB];
    logic [IDX_W-1:0]   rank [NLAB];

    logic [IDX_W-1:0]   vote_idx;
    logic [LABEL_W-1:0] cls_idx;
    logic [LABEL_W-1:0] best_label;
    logic [VOTE_W-1:0]  best_votes;
    logic [IDX_W-1:0]   best_rank;

    logic               accept;
    logic               label_bad;
    logic               keep;
    logic [K-1:0]       lt;
    logic               sel_valid;
    logic [LABEL_W-1:0] sel_label;
    logic [VOTE_W-1:0]  cur_cnt;
    logic [IDX_W-1:0]   cur_rank;
    logic               take;

    assign accept    = in_valid && in_ready;
    assign label_bad = {1'b0, in_label} >= (LABEL_W + 1)'(NUM_CLASS);
    assign keep      = accept && !label_bad;

    // Empty slots always accept, so the valid slots stay a sorted prefix and lt
    // is monotone: the first set bit is the insertion point.
    always_comb begin
        lt = '0;
        for (int i = 0; i < K; i++) begin
            lt[i] = !slot_valid[i] || (in_dist < slot_dist[i]);
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_label = '0;
        for (int i = 0; i < K; i++) begin
            if (vote_idx == IDX_W'(i)) begin
                sel_valid = slot_valid[i];
                sel_label = slot_label[i];
            end
        end
    end

    always_comb begin
        cur_cnt  = cnt[cls_idx];
        cur_rank = rank[cls_idx];
        take     = (cur_cnt > best_votes) ||
                   ((TIE_MODE != 0) && (cur_cnt == best_votes) &&
                    (cur_cnt != '0) && (cur_rank < best_rank));
    end

    // State register
    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start) state_nxt = S_COLLECT;
            S_COLLECT: if (accept && in_last) state_nxt = S_VOTE;
            S_VOTE:    if (vote_idx == IDX_W'(K - 1)) state_nxt = S_RESOLVE;
            S_RESOLVE: if (cls_idx == LABEL_W'(NUM_CLASS - 1)) state_nxt = S_DONE;
            S_DONE:    if (result_valid && result_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == S_COLLECT);
        busy      = (state == S_COLLECT) || (state == S_VOTE) || (state == S_RESOLVE);
        state_dbg = state;
    end

    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid      <= '0;
            for (int i = 0; i < K; i++) begin
                slot_dist[i]  <= '1;
                slot_label[i] <= '0;
            end
            for (int c = 0; c < NLAB; c++) begin
                cnt[c]  <= '0;
                rank[c] <= IDX_W'(K);
            end
            vote_idx        <= '0;
            cls_idx         <= '0;
            best_label      <= '0;
            best_votes      <= '0;
            best_rank       <= IDX_W'(K);
            label_err       <= 1'b0;
            result_valid    <= 1'b0;
            result_label    <= '0;
            result_votes    <= '0;
            result_min_dist <= '1;
            result_empty    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        slot_valid <= '0;
                        for (int i = 0; i < K; i++) begin
                            slot_dist[i]  <= '1;
                            slot_label[i] <= '0;
                        end
                        for (int c = 0; c < NLAB; c++) begin
                            cnt[c]  <= '0;
                            rank[c] <= IDX_W'(K);
                        end
                        vote_idx   <= '0;
                        cls_idx    <= '0;
                        best_label <= '0;
                        best_votes <= '0;
                        best_rank  <= IDX_W'(K);
                        label_err  <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept && label_bad) begin
                        label_err <= 1'b1;
                    end
                    if (keep) begin
                        if (lt[0]) begin
                            slot_valid[0] <= 1'b1;
                            slot_dist[0]  <= in_dist;
                            slot_label[0] <= in_label;
                        end
                        // Slots below the insertion point move down one place.
                        for (int i = 1; i < K; i++) begin
                            if (lt[i-1]) begin
                                slot_valid[i] <= slot_valid[i-1];
                                slot_dist[i]  <= slot_dist[i-1];
                                slot_label[i] <= slot_label[i-1];
                            end else if (lt[i]) begin
                                slot_valid[i] <= 1'b1;
                                slot_dist[i]  <= in_dist;
                                slot_label[i] <= in_label;
                            end
                        end
                    end
                end
                S_VOTE: begin
                    if (sel_valid) begin
                        cnt[sel_label] <= cnt[sel_label] + VOTE_W'(1);
                        if ((TIE_MODE != 0) && (cnt[sel_label] == '0)) begin
                            rank[sel_label] <= vote_idx;
                        end
                    end
                    vote_idx <= vote_idx + IDX_W'(1);
                end
                S_RESOLVE: begin
                    if (take) begin
                        best_label <= cls_idx;
                        best_votes <= cur_cnt;
                        best_rank  <= cur_rank;
                    end
                    cls_idx <= cls_idx + LABEL_W'(1);
                end
                S_DONE: begin
                    if (!result_valid) begin
                        result_valid    <= 1'b1;
                        result_label    <= best_label;
                        result_votes    <= best_votes;
                        result_min_dist <= slot_dist[0];
                        result_empty    <= !slot_valid[0];
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
